fp_mult_pipe: RTL and testbench

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

---
 rtl/fp_mult_pipe_if.sv | 28 ++
 rtl/fp_mult_pipe.sv | 98 +++++++++
 tb/tb_fp_mult_pipe.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mult_pipe_if.sv
// fp_mult_pipe_if: operand/result handshake bundle for fp_mult_pipe.
//   in_valid/in_ready : operand channel (in1, in2, round_mode)
//   out_valid/out_ready : result channel (out, out_ovf)
//   N : operand and result width (INT_LEN + FRAC_LEN of the multiplier)
// master = producer of operands / consumer of results, slave = the multiplier.
interface fp_mult_pipe_if #(
  parameter int N = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         round_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         out_ovf;

  modport master (
    output in_valid, in1, in2, round_mode, out_ready,
    input  in_ready, out_valid, out, out_ovf
  );

  modport slave (
    input  in_valid, in1, in2, round_mode, out_ready,
    output in_ready, out_valid, out, out_ovf
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: unsigned fixed-point multiplier with a valid/ready pipeline.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears every stage valid bit
//   bus : fp_mult_pipe_if slave
//         in1/in2 (N bits, FRAC_LEN fraction bits), round_mode (0 trunc,
//         1 round-half-up) accepted on in_valid && in_ready;
//         out/out_ovf delivered on out_valid && out_ready.
// The full-precision product is rounded and saturated/wrapped before the
// first register; the remaining STAGES-1 registers form an elastic shift
// chain, so latency is STAGES cycles for any STAGES value. Stage payload
// registers are not reset; outputs are gated to zero while the last stage
// is empty.
module fp_mult_pipe #(
  parameter int INT_LEN  = 8,
  parameter int FRAC_LEN = 4,
  parameter int STAGES   = 2,
  parameter int SAT_EN   = 1
) (
  input  logic          clk,
  input  logic          rst,
  fp_mult_pipe_if.slave bus
);

  localparam int N    = INT_LEN + FRAC_LEN;
  localparam int PW   = 2 * N;
  localparam int RW   = PW - FRAC_LEN + 1;
  localparam int HB   = (FRAC_LEN > 0) ? FRAC_LEN - 1 : 0;
  localparam int LAST = STAGES - 1;

  // Scale the full product down by FRAC_LEN, optionally adding the
  // half-LSB bit; one spare MSB keeps the rounding carry.
  function automatic logic [RW-1:0] round_res(input logic [PW-1:0] p,
                                              input logic          rm);
    logic half;
    half = (FRAC_LEN > 0) ? p[HB] : 1'b0;
    return RW'(p >> FRAC_LEN) + RW'(rm & half);
  endfunction

  // Returns {ovf, value}; ovf whenever any bit above N-1 is set.
  function automatic logic [N:0] sat_res(input logic [RW-1:0] r);
    logic         ovf;
    logic [N-1:0] v;
    ovf = |r[RW-1:N];
    if (ovf && (SAT_EN != 0)) v = '1;
    else                      v = r[N-1:0];
    return {ovf, v};
  endfunction

  logic [PW-1:0] prod;
  logic [N:0]    head_res;
  logic          vld_p [STAGES];
  logic [N:0]    res_p [STAGES];
  logic          ld    [STAGES];

  assign prod     = PW'(bus.in1) * PW'(bus.in2);
  assign head_res = sat_res(round_res(prod, bus.round_mode));

  // A stage may load when the output is being drained or when any stage
  // at or after it is empty: the chain then compresses toward the output.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    for (int k = LAST; k >= 0; k--) begin
      all_full = all_full & vld_p[k];
      ld[k]    = bus.out_ready | ~all_full;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic       src_vld;
    logic [N:0] src_res;

    // Stage k input: operands for stage 0, previous stage otherwise
    if (k == 0) begin : g_head
      assign src_vld = bus.in_valid;
      assign src_res = head_res;
    end else begin : g_body
      assign src_vld = vld_p[k-1];
      assign src_res = res_p[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)        vld_p[k] <= 1'b0;
      else if (ld[k]) vld_p[k] <= src_vld;
    end

    always_ff @(posedge clk) begin
      if (ld[k] && src_vld) res_p[k] <= src_res;
    end
  end

  // Output boundary
  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld_p[LAST];
  assign bus.out       = vld_p[LAST] ? res_p[LAST][N-1:0] : '0;
  assign bus.out_ovf   = vld_p[LAST] & res_p[LAST][N];

endmodule

// File: tb/tb_fp_mult_pipe.sv
module tb_fp_mult_pipe;

  typedef struct {
    logic [11:0] out;
    logic        ovf;
    int          cyc;
    bit          lat;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] a_i = '0;
  logic [11:0] b_i = '0;
  logic        rm_i = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy  [4];
  logic        vld  [4];
  logic        ovf  [4];
  logic [11:0] dout [4];

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    lat_chk = 0;
  int    st_of  [4] = '{2, 2, 1, 4};
  bit    sat_of [4] = '{1, 0, 1, 1};
  item_t q [4][$];
  bit          hold     [4];
  logic [11:0] hold_out [4];
  logic        hold_ovf [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mult_pipe_if #(.N(12)) bus0 ();
  fp_mult_pipe_if #(.N(12)) bus1 ();
  fp_mult_pipe_if #(.N(12)) bus2 ();
  fp_mult_pipe_if #(.N(12)) bus3 ();

  assign bus0.in_valid = in_valid; assign bus0.in1 = a_i; assign bus0.in2 = b_i;
  assign bus0.round_mode = rm_i;   assign bus0.out_ready = out_ready;
  assign bus1.in_valid = in_valid; assign bus1.in1 = a_i; assign bus1.in2 = b_i;
  assign bus1.round_mode = rm_i;   assign bus1.out_ready = out_ready;
  assign bus2.in_valid = in_valid; assign bus2.in1 = a_i; assign bus2.in2 = b_i;
  assign bus2.round_mode = rm_i;   assign bus2.out_ready = out_ready;
  assign bus3.in_valid = in_valid; assign bus3.in1 = a_i; assign bus3.in2 = b_i;
  assign bus3.round_mode = rm_i;   assign bus3.out_ready = out_ready;

  assign rdy[0] = bus0.in_ready; assign vld[0] = bus0.out_valid;
  assign ovf[0] = bus0.out_ovf;  assign dout[0] = bus0.out;
  assign rdy[1] = bus1.in_ready; assign vld[1] = bus1.out_valid;
  assign ovf[1] = bus1.out_ovf;  assign dout[1] = bus1.out;
  assign rdy[2] = bus2.in_ready; assign vld[2] = bus2.out_valid;
  assign ovf[2] = bus2.out_ovf;  assign dout[2] = bus2.out;
  assign rdy[3] = bus3.in_ready; assign vld[3] = bus3.out_valid;
  assign ovf[3] = bus3.out_ovf;  assign dout[3] = bus3.out;

  fp_mult_pipe                dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fp_mult_pipe #(.SAT_EN(0))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fp_mult_pipe #(.STAGES(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));
  fp_mult_pipe #(.STAGES(4))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Reference: 8.4 unsigned fixed point, product scaled by 1/16 with
  // optional round-half-up, then saturate or wrap at 12 bits.
  function automatic item_t model(input logic [11:0] a, input logic [11:0] b,
                                  input logic rm, input bit sat,
                                  input int c, input bit l);
    item_t  it;
    longint p, r;
    p = longint'(a) * longint'(b);
    r = p / 16;
    if (rm && (p % 16) >= 8) r = r + 1;
    it.ovf = (r >= 4096);
    if (it.ovf && sat) it.out = 12'hFFF;
    else               it.out = 12'(r % 4096);
    it.cyc = c;
    it.lat = l;
    return it;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: called at every falling edge; transfers seen here happen
  // at the following rising edge.
  task automatic mon();
    item_t it;
    if (rst) return;
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && out_ready) begin
        chk($sformatf("sb_extra%0d", i), q[i].size() != 0, 1);
        if (q[i].size() != 0) begin
          it = q[i].pop_front();
          chk($sformatf("sb_out%0d", i), dout[i], it.out);
          chk($sformatf("sb_ovf%0d", i), ovf[i], it.ovf);
          if (it.lat) chk($sformatf("sb_lat%0d", i), cyc - it.cyc, st_of[i]);
        end
      end
      if (hold[i] && vld[i]) begin
        chk($sformatf("hold_out%0d", i), dout[i], hold_out[i]);
        chk($sformatf("hold_ovf%0d", i), ovf[i], hold_ovf[i]);
      end
      hold[i]     = vld[i] && !out_ready;
      hold_out[i] = dout[i];
      hold_ovf[i] = ovf[i];
      if (in_valid && rdy[i]) q[i].push_back(model(a_i, b_i, rm_i, sat_of[i], cyc, lat_chk));
    end
  endtask

  task automatic half();
    @(negedge clk);
    mon();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      hold[i] = 0;
    end
  endtask

  // Present an operand and hold it until dut0 takes it; returns the
  // number of cycles it was offered. in_valid stays high afterwards.
  task automatic drive(input logic [11:0] a, input logic [11:0] b,
                       input logic rm, output int n);
    bit acc;
    a_i = a; b_i = b; rm_i = rm; in_valid = 1'b1;
    n = 0; acc = 0;
    while (!acc && n < 50) begin
      half();
      n++;
      acc = rdy[0];
      rise();
    end
    chk("accept", acc, 1);
  endtask

  task automatic directed(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic rm, input logic [11:0] e_sat, input logic o_sat,
                          input logic [11:0] e_wrap, input logic o_wrap);
    int n;
    drive(a, b, rm, n);
    in_valid = 1'b0;
    half();
    chk({tag, "_early"}, vld[0], 0);
    chk({tag, "_st1_vld"}, vld[2], 1);
    chk({tag, "_st1_out"}, dout[2], e_sat);
    rise();
    half();
    chk({tag, "_vld"}, vld[0], 1);
    chk({tag, "_out"}, dout[0], e_sat);
    chk({tag, "_ovf"}, ovf[0], o_sat);
    chk({tag, "_wrap_out"}, dout[1], e_wrap);
    chk({tag, "_wrap_ovf"}, ovf[1], o_wrap);
    rise();
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin half(); rise(); end
    for (int i = 0; i < 4; i++) chk($sformatf("%s_empty%0d", tag, i), q[i].size(), 0);
  endtask

  initial begin
    int    n;
    item_t e1;
    logic [11:0] ra, rb;
    logic        rr;

    // Reset state
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_vld%0d", i), vld[i], 0);
      chk($sformatf("rst_out%0d", i), dout[i], 0);
      chk($sformatf("rst_ovf%0d", i), ovf[i], 0);
      chk($sformatf("rst_rdy%0d", i), rdy[i], 1);
    end
    rise(); rise();
    rst = 1'b0;
    out_ready = 1'b1;
    lat_chk = 1;

    // Directed products
    directed("mul", 12'h038, 12'h020, 1'b0, 12'h070, 1'b0, 12'h070, 1'b0);
    directed("trunc", 12'h001, 12'h008, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    directed("round", 12'h001, 12'h008, 1'b1, 12'h001, 1'b0, 12'h001, 1'b0);
    directed("ovf", 12'hFFF, 12'h020, 1'b0, 12'hFFF, 1'b1, 12'hFFE, 1'b1);
    directed("rndovf", 12'h100, 12'h100, 1'b1, 12'hFFF, 1'b1, 12'h000, 1'b1);
    drain("dir");

    // Back-to-back stream, one acceptance per cycle
    for (int k = 0; k < 8; k++) begin
      drive(12'($urandom), 12'($urandom), 1'($urandom), n);
      chk($sformatf("tput%0d", k), n, 1);
    end
    drain("stream");

    // Stall with a full pipeline mid-stream
    lat_chk = 0;
    out_ready = 1'b0;
    ra = 12'h123; rb = 12'h045; rr = 1'b1;
    e1 = model(ra, rb, rr, 1, 0, 0);
    drive(ra, rb, rr, n);
    chk("stall_acc1", n, 1);
    drive(12'h0F0, 12'h0F0, 1'b0, n);
    chk("stall_acc2", n, 1);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      half();
      chk("stall_rdy", rdy[0], 0);
      chk("stall_vld", vld[0], 1);
      chk("stall_out", dout[0], e1.out);
      rise();
    end
    out_ready = 1'b1;
    drive(12'h7FF, 12'h011, 1'b1, n);
    chk("resume_acc", n, 1);
    drive(12'h010, 12'h010, 1'b0, n);
    drive(12'h0AB, 12'h0CD, 1'b1, n);
    drain("stall");

    // Asynchronous reset with results in flight
    lat_chk = 1;
    drive(12'h055, 12'h066, 1'b0, n);
    drive(12'h077, 12'h088, 1'b1, n);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    flush();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arst_vld%0d", i), vld[i], 0);
      chk($sformatf("arst_out%0d", i), dout[i], 0);
      chk($sformatf("arst_rdy%0d", i), rdy[i], 1);
    end
    rise(); rise();
    chk("rst_hold_vld", vld[3], 0);
    rst = 1'b0;
    repeat (6) begin
      half();
      for (int i = 0; i < 4; i++) chk($sformatf("stale%0d", i), vld[i], 0);
      rise();
    end
    directed("post_rst", 12'h038, 12'h020, 1'b0, 12'h070, 1'b0, 12'h070, 1'b0);
    drain("rst");

    // Random traffic with random backpressure
    lat_chk = 0;
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom);
      a_i       = ($urandom_range(0, 3) == 0) ? 12'hFFF - 12'($urandom_range(0, 40)) : 12'($urandom);
      b_i       = 12'($urandom);
      rm_i      = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      half();
      rise();
    end
    drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
